// File: rtl/glay_kernel_cu_sync.sv
// glay_kernel_cu_sync: takes descriptors from the kernel control FSM and
// dispatches them to every graph cluster. It also collects each cluster's done
// pulse into sticky bits and counts the busy cycles of the current run.
module glay_kernel_cu_sync #(
  parameter int NUM_GRAPH_CLUSTERS = 4,
  parameter int DESC_W             = 512,
  parameter int CYCLE_CNT_W        = 32
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          descriptor_valid_in,
  input  logic [DESC_W-1:0]             descriptor_payload_in,
  input  logic [NUM_GRAPH_CLUSTERS-1:0] cu_idle_in,
  input  logic [NUM_GRAPH_CLUSTERS-1:0] cu_descriptor_ready_in,
  input  logic [NUM_GRAPH_CLUSTERS-1:0] cu_done_pulse_in,
  output logic [NUM_GRAPH_CLUSTERS-1:0] cu_descriptor_valid_out,
  output logic [DESC_W-1:0]             cu_descriptor_payload_out,
  output logic [NUM_GRAPH_CLUSTERS-1:0] glay_cu_setup_out,
  output logic [NUM_GRAPH_CLUSTERS-1:0] glay_cu_done_out,
  output logic [CYCLE_CNT_W-1:0]        busy_cycles_out
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic                          valid_q;
  logic [NUM_GRAPH_CLUSTERS-1:0] pending_q, pending_d;
  logic [NUM_GRAPH_CLUSTERS-1:0] cu_valid_q, cu_valid_d;
  logic [DESC_W-1:0]             payload_q, payload_d;
  logic [NUM_GRAPH_CLUSTERS-1:0] setup_q, setup_d;
  logic [NUM_GRAPH_CLUSTERS-1:0] done_q, done_d;
  logic [CYCLE_CNT_W-1:0]        busy_q, busy_d;

  logic                          start;
  logic                          launch;
  logic                          abort;
  logic [NUM_GRAPH_CLUSTERS-1:0] accept;
  logic [CYCLE_CNT_W-1:0]        busy_inc;

  assign start    = descriptor_valid_in & ~valid_q;
  assign accept   = cu_valid_q & cu_descriptor_ready_in;
  assign busy_inc = (busy_q == '1) ? busy_q : busy_q + CYCLE_CNT_W'(1);

  // Next-state logic: the launch and abort actions are collected as flags and
  // applied once after the per-state decisions, so IDLE and DONE share one start path.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cu_valid_d = cu_valid_q;
    payload_d  = payload_q;
    setup_d    = setup_q;
    done_d     = done_q;
    busy_d     = busy_q;
    launch     = 1'b0;
    abort      = 1'b0;

    case (state_q)
      S_IDLE: begin
        setup_d = ~cu_idle_in;
        launch  = start;
      end
      S_DISPATCH: begin
        setup_d = '0;
        if (!descriptor_valid_in) begin
          abort = 1'b1;
        end else begin
          pending_d  = pending_q & ~accept;
          cu_valid_d = cu_valid_q & ~accept;
          // Only clusters that hold the descriptor (accepted now or earlier) may finish.
          done_d     = done_q | (cu_done_pulse_in & ~pending_d);
          busy_d     = busy_inc;
          if (pending_d == '0) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        setup_d = '0;
        if (!descriptor_valid_in) begin
          abort = 1'b1;
        end else begin
          done_d = done_q | cu_done_pulse_in;
          busy_d = busy_inc;
          if (&done_d) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        setup_d = '0;
        launch  = start;
      end
    endcase

    if (launch) begin
      payload_d  = descriptor_payload_in;
      pending_d  = '1;
      cu_valid_d = '1;
      done_d     = '0;
      busy_d     = '0;
      state_d    = S_DISPATCH;
    end

    if (abort) begin
      pending_d  = '0;
      cu_valid_d = '0;
      done_d     = '0;
      state_d    = S_IDLE;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      pending_q  <= '0;
      cu_valid_q <= '0;
      payload_q  <= '0;
      setup_q    <= '1;
      done_q     <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= descriptor_valid_in;
      pending_q  <= pending_d;
      cu_valid_q <= cu_valid_d;
      payload_q  <= payload_d;
      setup_q    <= setup_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign cu_descriptor_valid_out   = cu_valid_q;
  assign cu_descriptor_payload_out = payload_q;
  assign glay_cu_setup_out         = setup_q;
  assign glay_cu_done_out          = done_q;
  assign busy_cycles_out           = busy_q;

endmodule

// File: tb/tb_glay_kernel_cu_sync.sv
// Testbench for glay_kernel_cu_sync: directed scenarios followed by random
// traffic. All outputs are compared against a cluster-level reference model.
module tb_glay_kernel_cu_sync;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_DISP = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_DONE = 3;

  logic          ap_clk = 1'b0;
  logic          areset;
  logic          v;
  logic [DW-1:0] pay;
  logic [N-1:0]  idle, ready, pulse;
  logic [N-1:0]  valid_o, setup_o, done_o;
  logic [DW-1:0] pay_o;
  logic [CW-1:0] busy_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, tracked per cluster and per run.
  int            m_phase;
  bit            m_prev;
  logic [N-1:0]  m_acc;
  logic [N-1:0]  m_done;
  logic [N-1:0]  m_setup;
  logic [DW-1:0] m_pay;
  longint        m_busy;

  glay_kernel_cu_sync #(
    .NUM_GRAPH_CLUSTERS(N),
    .DESC_W            (DW),
    .CYCLE_CNT_W       (CW)
  ) dut (
    .ap_clk                   (ap_clk),
    .areset                   (areset),
    .descriptor_valid_in      (v),
    .descriptor_payload_in    (pay),
    .cu_idle_in               (idle),
    .cu_descriptor_ready_in   (ready),
    .cu_done_pulse_in         (pulse),
    .cu_descriptor_valid_out  (valid_o),
    .cu_descriptor_payload_out(pay_o),
    .glay_cu_setup_out        (setup_o),
    .glay_cu_done_out         (done_o),
    .busy_cycles_out          (busy_o)
  );

  always #5 ap_clk = ~ap_clk;

  task check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task model_reset();
    m_phase = PH_IDLE;
    m_prev  = 1'b0;
    m_acc   = '0;
    m_done  = '0;
    m_setup = '1;
    m_pay   = '0;
    m_busy  = 0;
  endtask

  task model_begin_run();
    m_pay   = pay;
    m_acc   = '0;
    m_done  = '0;
    m_busy  = 0;
    m_phase = PH_DISP;
  endtask

  task model_abort();
    m_acc   = '0;
    m_done  = '0;
    m_phase = PH_IDLE;
  endtask

  // One clock of the reference model, evaluated on the inputs about to be sampled.
  task model_step();
    bit start;
    start = v && !m_prev;
    case (m_phase)
      PH_IDLE: begin
        for (int i = 0; i < N; i++) m_setup[i] = !idle[i];
        if (start) model_begin_run();
      end
      PH_DISP: begin
        m_setup = '0;
        if (!v) model_abort();
        else begin
          for (int i = 0; i < N; i++) if (ready[i]) m_acc[i] = 1'b1;
          for (int i = 0; i < N; i++) if (m_acc[i] && pulse[i]) m_done[i] = 1'b1;
          m_busy++;
          if (m_acc == '1) m_phase = PH_RUN;
        end
      end
      PH_RUN: begin
        m_setup = '0;
        if (!v) model_abort();
        else begin
          for (int i = 0; i < N; i++) if (pulse[i]) m_done[i] = 1'b1;
          m_busy++;
          if (m_done == '1) m_phase = PH_DONE;
        end
      end
      default: begin
        m_setup = '0;
        if (start) model_begin_run();
      end
    endcase
    m_prev = v;
  endtask

  task check_model();
    logic [N-1:0]  exp_valid;
    logic [CW-1:0] exp_busy;
    exp_valid = (m_phase == PH_DISP) ? ~m_acc : '0;
    exp_busy  = (m_busy > 15) ? CW'(15) : CW'(m_busy);
    check("valid_out", 64'(valid_o), 64'(exp_valid));
    check("setup_out", 64'(setup_o), 64'(m_setup));
    check("done_out",  64'(done_o),  64'(m_done));
    check("busy_out",  64'(busy_o),  64'(exp_busy));
    check("payload",   pay_o,        m_pay);
  endtask

  task tick();
    model_step();
    @(posedge ap_clk);
    #1;
    check_model();
  endtask

  task check_reset_values(input string tag);
    check({tag, "_valid"}, 64'(valid_o), 64'h0);
    check({tag, "_setup"}, 64'(setup_o), 64'hF);
    check({tag, "_done"},  64'(done_o),  64'h0);
    check({tag, "_busy"},  64'(busy_o),  64'h0);
    check({tag, "_pay"},   pay_o,        64'h0);
  endtask

  initial begin
    areset = 1'b1;
    v      = 1'b0;
    pay    = '0;
    idle   = 4'b1011;
    ready  = '0;
    pulse  = '0;
    model_reset();
    #22;
    check_reset_values("reset");
    areset = 1'b0;
    tick();
    check("tp_setup_after_reset", 64'(setup_o), 64'h4);

    // All clusters ready on the first dispatch cycle.
    v = 1'b1; pay = 64'hA5A5_A5A5_A5A5_A5A5; ready = 4'b1111;
    tick();
    check("tp_valid_all", 64'(valid_o), 64'hF);
    check("tp_payload",   pay_o, 64'hA5A5_A5A5_A5A5_A5A5);
    tick();
    check("tp_valid_one_cycle", 64'(valid_o), 64'h0);
    pulse = 4'b1111; tick();
    pulse = '0; v = 1'b0; tick();
    check("tp_done_full", 64'(done_o), 64'hF);

    // Acceptance in order 2, 0, 3, 1.
    v = 1'b1; pay = 64'h1234_5678_9ABC_DEF0; ready = '0; tick();
    ready = 4'b0100; tick(); check("tp_seq1", 64'(valid_o), 64'hB);
    ready = 4'b0001; tick(); check("tp_seq2", 64'(valid_o), 64'hA);
    ready = 4'b1000; tick(); check("tp_seq3", 64'(valid_o), 64'h2);
    ready = 4'b0010; tick(); check("tp_seq4", 64'(valid_o), 64'h0);
    check("tp_busy_at_run", 64'(busy_o), 64'h4);
    ready = '0;

    // Done pulses on clusters 1, 3, 0, 2.
    pulse = 4'b0010; tick(); check("tp_done_a", 64'(done_o), 64'h2);
    pulse = '0; tick();
    pulse = 4'b1000; tick(); check("tp_done_b", 64'(done_o), 64'hA);
    pulse = '0; tick(); tick();
    pulse = 4'b0001; tick(); check("tp_done_c", 64'(done_o), 64'hB);
    pulse = '0; repeat (4) tick();
    pulse = 4'b0100; tick(); check("tp_done_d", 64'(done_o), 64'hF);
    pulse = 4'b1111; tick(); tick();
    check("tp_busy_frozen", 64'(busy_o), 64'hF);
    pulse = '0; v = 1'b0; tick();
    v = 1'b1; tick();
    check("tp_restart_clears_done", 64'(done_o), 64'h0);

    // Abort during RUN with partial done.
    ready = 4'b1111; tick();
    ready = '0; pulse = 4'b0011; tick();
    check("tp_partial_done", 64'(done_o), 64'h3);
    pulse = '0; v = 1'b0; tick();
    check("tp_abort_done",  64'(done_o),  64'h0);
    check("tp_abort_valid", 64'(valid_o), 64'h0);
    idle = 4'b0110; tick();
    check("tp_abort_setup", 64'(setup_o), 64'h9);

    // Long run saturates the 4-bit counter, then an asynchronous reset mid-run.
    v = 1'b1; ready = 4'b1111; tick(); tick();
    ready = '0; repeat (20) tick();
    check("tp_busy_sat", 64'(busy_o), 64'hF);
    #2 areset = 1'b1;
    #1 check_reset_values("async_reset");
    #2 areset = 1'b0;
    v = 1'b0;
    model_reset();
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 14) == 0) v = ~v;
      pay   = {$urandom(), $urandom()};
      idle  = N'($urandom());
      ready = N'($urandom());
      pulse = ($urandom_range(0, 2) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/glay_kernel_cu_sync.md
Name: glay_kernel_cu_sync

Overview:
- Sits directly downstream of the kernel control FSM, between it and the graph clusters.
- On each rising edge of the control's descriptor valid, latches the descriptor and dispatches it to every cluster with a per-cluster valid/ready handshake.
- Collects each cluster's one-cycle done pulse into sticky done bits, and reports per-cluster setup status back to control.
- Counts busy cycles for the current run.

Parameters:
- NUM_GRAPH_CLUSTERS, default CU_COUNT_GLOBAL: number of clusters served; legal range ≥1.
- DESC_W, default 512: descriptor payload width in bits.
- CYCLE_CNT_W, default 32: busy-cycle counter width.

Ports:
- ap_clk  in  1  kernel clock.
- areset  in  1  asynchronous, active-high reset.
- descriptor_valid_in  in  1  level valid from control.
- descriptor_payload_in  in  DESC_W  descriptor from control.
- cu_idle_in  in  NUM_GRAPH_CLUSTERS  cluster idle/ready-for-setup, one bit per cluster.
- cu_descriptor_ready_in  in  NUM_GRAPH_CLUSTERS  cluster accepts descriptor.
- cu_done_pulse_in  in  NUM_GRAPH_CLUSTERS  one-cycle cluster done.
- cu_descriptor_valid_out  out  NUM_GRAPH_CLUSTERS  per-cluster descriptor valid.
- cu_descriptor_payload_out  out  DESC_W  latched descriptor, shared by all clusters.
- glay_cu_setup_out  out  NUM_GRAPH_CLUSTERS  1 = cluster not yet set up; feeds control setup input.
- glay_cu_done_out  out  NUM_GRAPH_CLUSTERS  sticky per-cluster done; feeds control done input.
- busy_cycles_out  out  CYCLE_CNT_W  cycles spent in DISPATCH+RUN for the current run.

Behaviour:
- Reset values: all outputs registered.
  - State=IDLE; valid_q=0; pending mask=0.
  - cu_descriptor_valid_out=0; cu_descriptor_payload_out=0.
  - glay_cu_setup_out=all ones; glay_cu_done_out=0; busy_cycles_out=0.
  - Reset asserted mid-operation returns to these values immediately, independent of clock.
- Start detection: valid_q registers descriptor_valid_in. start = descriptor_valid_in & ~valid_q.
- States: IDLE, DISPATCH, RUN, DONE.
- IDLE:
  - glay_cu_setup_out <= ~cu_idle_in each cycle (1-cycle latency).
  - On start:
    - payload_out <= payload_in; pending <= all ones; cu_descriptor_valid_out <= all ones.
    - done_out <= 0; busy_cycles <= 0.
    - Go to DISPATCH. Valid_out rises the cycle after start.
- DISPATCH:
  - glay_cu_setup_out=0; payload_out held stable.
  - Acceptance of cluster i = valid_out[i] & ready_in[i]. Clear pending[i] and valid_out[i] the next cycle.
  - busy_cycles increments each cycle.
  - When pending after update is zero, go to RUN.
  - Done pulse from cluster i is recorded only if i is accepted in the same or an earlier cycle; otherwise ignored.
- RUN:
  - done_out[i] <= done_out[i] | cu_done_pulse_in[i].
  - busy_cycles increments, saturating at all ones (no wrap).
  - When &(done_out | cu_done_pulse_in), go to DONE (done_out fully set the same edge).
- DONE:
  - done_out and busy_cycles held; glay_cu_setup_out=0.
  - Further done pulses are ignored.
  - On start: same actions as IDLE start, go to DISPATCH.
  - descriptor_valid_in low is normal here.
- Abort: if descriptor_valid_in is low while in DISPATCH or RUN:
  - Next cycle: valid_out=0, pending=0, done_out=0; go to IDLE.
  - busy_cycles held.
- Simultaneous events:
  - start has priority over abort (cannot co-occur).
  - All clusters ready in the first dispatch cycle: DISPATCH lasts exactly 1 cycle.
  - NUM_GRAPH_CLUSTERS=1 is legal; all reductions degenerate correctly.
- Payload_out changes only on start.

Test Plan:
- Reset release, NUM=4, cu_idle_in=4'b1011 → setup_out=4'b0100 one cycle later; done_out=0, valid_out=0.
- descriptor_valid_in rises with payload 0xA5…; all ready_in=1 → valid_out=4'b1111 for exactly 1 cycle, then RUN; payload_out=0xA5….
- ready_in asserted in order cluster 2, 0, 3, 1 on successive cycles → valid_out goes 1111→1011→1010→0010→0000; RUN entered after the 4th acceptance; busy_cycles=4 at entry.
- In RUN, done pulses on clusters 1, 3, 0, 2 at cycles 10, 12, 15, 20 → done_out accumulates 0010, 1010, 1011, 1111; DONE; busy_cycles frozen; second start clears done_out to 0.
- descriptor_valid_in dropped in RUN with done_out=4'b0011 → IDLE next cycle; done_out=0; valid_out=0; setup_out follows ~cu_idle_in again.
- CYCLE_CNT_W=4 with a run longer than 15 cycles → busy_cycles_out saturates at 4'hF; areset asserted mid-RUN → all outputs return to reset values asynchronously.
